// File: rtl/adc_emu_pkg.sv
// Shared types and constants for the dual-lane serial ADC emulator.
package adc_emu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT,
    S_QUIET
  } adc_state_e;

  localparam int unsigned ADC_BITS_DEF = 12;
  localparam int unsigned NUM_LANES    = 2;

endpackage

// File: rtl/adc_shift_lane.sv
// One serial lane: parallel load, MSB-first shift with zero fill, registered bit output.
module adc_shift_lane
  import adc_emu_pkg::*;
#(
  parameter int unsigned ADC_BITS = ADC_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [ADC_BITS-1:0] value,
  input  logic                shift,
  output logic                sdata
);

  logic [ADC_BITS-1:0] shreg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q <= '0;
      sdata   <= 1'b0;
    end else begin
      if (load) begin
        shreg_q <= value;
      end else if (shift) begin
        shreg_q <= {shreg_q[ADC_BITS-2:0], 1'b0};
      end
      // Line idles low whenever the lane is not actively shifting.
      sdata <= shift & shreg_q[ADC_BITS-1];
    end
  end

endmodule

// File: rtl/adc_serial_emulator.sv
// Dual-channel serial ADC emulator: cs rising edge captures both codes and shifts them
// out MSB-first on sdata[1:0], followed by a quiet gap before the next start is accepted.
module adc_serial_emulator
  import adc_emu_pkg::*;
#(
  parameter int unsigned ADC_BITS     = ADC_BITS_DEF,
  parameter int unsigned DATA_DELAY   = 1,
  parameter int unsigned QUIET_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cs,
  input  logic [ADC_BITS-1:0] ch0_value,
  input  logic [ADC_BITS-1:0] ch1_value,
  input  logic                overrun_clr,
  output logic [1:0]          sdata,
  output logic                sample_strobe,
  output logic                busy,
  output logic                overrun,
  output logic [CNT_W-1:0]    conv_count
);

  localparam int unsigned BIT_W   = $clog2(ADC_BITS + 1);
  localparam int unsigned DLY_MAX = (DATA_DELAY > QUIET_CYCLES) ? DATA_DELAY : QUIET_CYCLES;
  localparam int unsigned DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

  localparam logic [DLY_W-1:0] WAIT_LAST  = DLY_W'((DATA_DELAY >= 2) ? DATA_DELAY - 2 : 0);
  localparam logic [DLY_W-1:0] QUIET_LAST = DLY_W'((QUIET_CYCLES >= 1) ? QUIET_CYCLES - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_END    = BIT_W'(ADC_BITS);

  adc_state_e       state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
  logic             cs_q;
  logic             start;
  logic             load;
  logic             shift;
  logic             strobe_d;
  logic             busy_d;
  logic             overrun_d;
  logic [CNT_W-1:0] count_d;

  assign start = cs & ~cs_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    dly_cnt_d = dly_cnt_q;
    load      = 1'b0;
    shift     = 1'b0;
    strobe_d  = 1'b0;
    count_d   = conv_count;
    overrun_d = overrun;

    if (start && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          strobe_d  = 1'b1;
          count_d   = conv_count + CNT_W'(1);
          bit_cnt_d = '0;
          dly_cnt_d = '0;
          state_d   = (DATA_DELAY > 1) ? S_WAIT : S_SHIFT;
        end
      end
      S_WAIT: begin
        if (dly_cnt_q == WAIT_LAST) begin
          state_d = S_SHIFT;
        end else begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end
      end
      S_SHIFT: begin
        // One extra cycle after the LSB drives the line back to zero.
        if (bit_cnt_q == BIT_END) begin
          dly_cnt_d = '0;
          state_d   = (QUIET_CYCLES > 0) ? S_QUIET : S_IDLE;
        end else begin
          shift     = 1'b1;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      S_QUIET: begin
        if (dly_cnt_q == QUIET_LAST) begin
          state_d = S_IDLE;
        end else begin
          dly_cnt_d = dly_cnt_q + DLY_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // cs_q resets high so a cs held across reset release is not taken as a start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      dly_cnt_q     <= '0;
      cs_q          <= 1'b1;
      sample_strobe <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
      conv_count    <= '0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      dly_cnt_q     <= dly_cnt_d;
      cs_q          <= cs;
      sample_strobe <= strobe_d;
      busy          <= busy_d;
      overrun       <= overrun_d;
      conv_count    <= count_d;
    end
  end

  logic [ADC_BITS-1:0] lane_value [NUM_LANES];
  assign lane_value[0] = ch0_value;
  assign lane_value[1] = ch1_value;

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    adc_shift_lane #(
      .ADC_BITS(ADC_BITS)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .load (load),
      .value(lane_value[n]),
      .shift(shift),
      .sdata(sdata[n])
    );
  end

endmodule
